// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath.
// master = controller side (drives datapath controls), slave = datapath side.
interface multicycle_control_if #(
   parameter int CNT_W   = 16,
   parameter int ALUOP_W = 2
);
   logic [5:0]         instruction;
   logic               mem_ready;
   logic               PCWrite, PCWriteCondE, PCWriteCondNE, IorD, MemRead, MemWrite;
   logic               MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
   logic [1:0]         PCSource, ALUSrcB;
   logic [ALUOP_W-1:0] ALUOp;
   logic               Illegal;
   logic [CNT_W-1:0]   Retired;
   logic [3:0]         State;

   modport master (
      input  instruction, mem_ready,
      output PCWrite, PCWriteCondE, PCWriteCondNE, IorD, MemRead, MemWrite,
             MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
             ALUOp, Illegal, Retired, State
   );
   modport slave (
      output instruction, mem_ready,
      input  PCWrite, PCWriteCondE, PCWriteCondNE, IorD, MemRead, MemWrite,
             MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
             ALUOp, Illegal, Retired, State
   );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with retired-instruction counter.
// Define MULTICYCLE_CONTROL_IMM_LOGIC_EN to accept andi/ori as immediate ops.
module multicycle_control #(
   parameter int CNT_W   = 16,
   parameter int ALUOP_W = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   multicycle_control_if.master bus
);
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
      MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB   = 4'd7,
      BRANCH = 4'd8,  JUMP   = 4'd9,  IMMEX  = 4'd10, IMMWB = 4'd11
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] retired;
   logic             immLogic;
   logic             knownOp;
   logic [1:0]       aluOp;

`ifdef MULTICYCLE_CONTROL_IMM_LOGIC_EN
   assign immLogic = (bus.instruction == OP_ANDI) || (bus.instruction == OP_ORI);
`else
   assign immLogic = 1'b0;
`endif

   always_comb begin
      case (bus.instruction)
         OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: knownOp = 1'b1;
         default:                                           knownOp = immLogic;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FETCH;
         retired <= '0;
      end else begin
         case (state)
            FETCH:  if (bus.mem_ready) state <= DECODE;
            DECODE: begin
               case (bus.instruction)
                  OP_R:           state <= EXEC;
                  OP_LW, OP_SW:   state <= MEMADR;
                  OP_BEQ, OP_BNE: state <= BRANCH;
                  OP_J:           state <= JUMP;
                  OP_ADDI:        state <= IMMEX;
                  default:        state <= immLogic ? IMMEX : FETCH;
               endcase
            end
            MEMADR: state <= (bus.instruction == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  if (bus.mem_ready) state <= MEMWB;
            MEMWR:  if (bus.mem_ready) begin
               state   <= FETCH;
               retired <= retired + CNT_W'(1);
            end
            EXEC:   state <= RWB;
            IMMEX:  state <= IMMWB;
            MEMWB, RWB, BRANCH, JUMP, IMMWB: begin
               state   <= FETCH;
               retired <= retired + CNT_W'(1);
            end
            default: state <= FETCH;
         endcase
      end
   end

   assign bus.State   = state;
   assign bus.Retired = retired;
   assign bus.ALUOp   = ALUOP_W'(aluOp);

   // Controls decode straight from state so memory stalls see mem_ready the same cycle.
   always_comb begin
      bus.PCWrite       = 1'b0;
      bus.PCWriteCondE  = 1'b0;
      bus.PCWriteCondNE = 1'b0;
      bus.IorD          = 1'b0;
      bus.MemRead       = 1'b0;
      bus.MemWrite      = 1'b0;
      bus.MemtoReg      = 1'b0;
      bus.IRWrite       = 1'b0;
      bus.ALUSrcA       = 1'b0;
      bus.RegWrite      = 1'b0;
      bus.RegDst        = 1'b0;
      bus.PCSource      = 2'b00;
      bus.ALUSrcB       = 2'b00;
      bus.Illegal       = 1'b0;
      aluOp             = 2'b00;
      if (!rst) begin
         case (state)
            FETCH: begin
               bus.MemRead = 1'b1;
               bus.ALUSrcB = 2'b01;
               bus.IRWrite = bus.mem_ready;
               bus.PCWrite = bus.mem_ready;
            end
            DECODE: begin
               bus.ALUSrcB = 2'b11;
               bus.Illegal = !knownOp;
            end
            MEMADR: begin
               bus.ALUSrcA = 1'b1;
               bus.ALUSrcB = 2'b10;
            end
            MEMRD: begin
               bus.MemRead = 1'b1;
               bus.IorD    = 1'b1;
            end
            MEMWB: begin
               bus.MemtoReg = 1'b1;
               bus.RegWrite = 1'b1;
            end
            MEMWR: begin
               bus.MemWrite = 1'b1;
               bus.IorD     = 1'b1;
            end
            EXEC: begin
               bus.ALUSrcA = 1'b1;
               aluOp       = 2'b10;
            end
            RWB: begin
               bus.RegDst   = 1'b1;
               bus.RegWrite = 1'b1;
            end
            BRANCH: begin
               bus.ALUSrcA       = 1'b1;
               aluOp             = 2'b01;
               bus.PCSource      = 2'b01;
               bus.PCWriteCondE  = (bus.instruction == OP_BEQ);
               bus.PCWriteCondNE = (bus.instruction == OP_BNE);
            end
            JUMP: begin
               bus.PCWrite  = 1'b1;
               bus.PCSource = 2'b10;
            end
            IMMEX: begin
               bus.ALUSrcA = 1'b1;
               bus.ALUSrcB = 2'b10;
               aluOp       = immLogic ? 2'b11 : 2'b00;
            end
            IMMWB: bus.RegWrite = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into
// its list of visited steps and the expected controls per step are tabulated.
module tb_multicycle_control;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  instruction = '0;
   logic        memReady = 1'b0;
   logic [15:0] retModel = '0;
   int          nTests = 0;
   int          nFail  = 0;

   multicycle_control_if #(.CNT_W(16), .ALUOP_W(3)) ifBig ();
   multicycle_control_if #(.CNT_W(2),  .ALUOP_W(2)) ifSmall ();

   assign ifBig.instruction   = instruction;
   assign ifBig.mem_ready     = memReady;
   assign ifSmall.instruction = instruction;
   assign ifSmall.mem_ready   = memReady;

   multicycle_control #(.CNT_W(16), .ALUOP_W(3)) dut      (.clk(clk), .rst(rst), .bus(ifBig));
   multicycle_control #(.CNT_W(2),  .ALUOP_W(2)) dutSmall (.clk(clk), .rst(rst), .bus(ifSmall));

   always #5 clk = ~clk;

   function automatic bit legal(input logic [5:0] op);
      bit l;
      l = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
          (op == OP_BNE) || (op == OP_J) || (op == OP_ADDI);
`ifdef MULTICYCLE_CONTROL_IMM_LOGIC_EN
      l = l || (op == OP_ANDI) || (op == OP_ORI);
`endif
      return l;
   endfunction

   // {PCWrite,CondE,CondNE,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,PCSource,ALUSrcB,ALUOp[2:0],Illegal}
   function automatic logic [18:0] expCtrl(input int st, input logic [5:0] op, input logic mr);
      logic pcw, ce, cne, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill;
      logic [1:0] pcs, asb;
      logic [2:0] aop;
      {pcw, ce, cne, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill} = '0;
      pcs = 2'b00; asb = 2'b00; aop = 3'b000;
      case (st)
         0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
         1:  begin asb = 2'b11; ill = !legal(op); end
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mrd = 1; iord = 1; end
         4:  begin m2r = 1; rw = 1; end
         5:  begin mwr = 1; iord = 1; end
         6:  begin asa = 1; aop = 3'b010; end
         7:  begin rd = 1; rw = 1; end
         8:  begin asa = 1; aop = 3'b001; pcs = 2'b01; ce = (op == OP_BEQ); cne = (op == OP_BNE); end
         9:  begin pcw = 1; pcs = 2'b10; end
         10: begin asa = 1; asb = 2'b10; aop = (op == OP_ADDI) ? 3'b000 : 3'b011; end
         11: rw = 1;
         default: ;
      endcase
      return {pcw, ce, cne, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop, ill};
   endfunction

   function automatic logic [18:0] actCtrl();
      return {ifBig.PCWrite, ifBig.PCWriteCondE, ifBig.PCWriteCondNE, ifBig.IorD,
              ifBig.MemRead, ifBig.MemWrite, ifBig.MemtoReg, ifBig.IRWrite,
              ifBig.ALUSrcA, ifBig.RegWrite, ifBig.RegDst, ifBig.PCSource,
              ifBig.ALUSrcB, ifBig.ALUOp, ifBig.Illegal};
   endfunction

   // Runs one instruction from FETCH; stallN >= 0 holds mem_ready low that many
   // cycles in every memory step, otherwise mem_ready is random with pReady %.
   task automatic runInstr(input logic [5:0] op, input int pReady, input int stallN);
      int   steps[$];
      int   i;
      int   stall;
      bit   memStep;
      logic [18:0] exp;
      steps = '{0, 1};
      if (op == OP_LW)                       steps = '{0, 1, 2, 3, 4};
      else if (op == OP_SW)                  steps = '{0, 1, 2, 5};
      else if (op == OP_R)                   steps = '{0, 1, 6, 7};
      else if (op == OP_BEQ || op == OP_BNE) steps = '{0, 1, 8};
      else if (op == OP_J)                   steps = '{0, 1, 9};
      else if (legal(op))                    steps = '{0, 1, 10, 11};
      instruction = op;
      i = 0;
      stall = 0;
      while (i < steps.size()) begin
         memStep = (steps[i] == 0) || (steps[i] == 3) || (steps[i] == 5);
         if (!memStep)         memReady = 1'($urandom_range(0, 1));
         else if (stallN >= 0) memReady = (stall >= stallN);
         else                  memReady = (stall >= 20) || ($urandom_range(0, 99) < pReady);
         @(negedge clk);
         exp = expCtrl(steps[i], op, memReady);
         nTests++;
         if (ifBig.State !== 4'(steps[i])) begin
            nFail++;
            $display("FAIL state op=%b got %0d want %0d", op, ifBig.State, steps[i]);
         end
         nTests++;
         if (actCtrl() !== exp) begin
            nFail++;
            $display("FAIL ctrl op=%b step=%0d got %b want %b", op, steps[i], actCtrl(), exp);
         end
         nTests++;
         if (ifBig.Retired !== retModel || ifSmall.Retired !== retModel[1:0]) begin
            nFail++;
            $display("FAIL retired got %0d/%0d want %0d/%0d", ifBig.Retired, ifSmall.Retired,
                     retModel, retModel[1:0]);
         end
         @(posedge clk); #1;
         if (!memStep || memReady) begin i++; stall = 0; end
         else stall++;
      end
      if (legal(op)) retModel++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      memReady = 1'b1;
      instruction = 6'h3f;
      @(posedge clk); #1;
      @(negedge clk);
      nTests++;
      if (actCtrl() !== '0 || ifSmall.Illegal !== 1'b0) begin
         nFail++;
         $display("FAIL reset_ctrl got %b want 0", actCtrl());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      retModel = '0;
      nTests++;
      if (ifBig.State !== 4'd0 || ifBig.Retired !== 16'd0 || ifSmall.Retired !== 2'd0) begin
         nFail++;
         $display("FAIL reset_state got st=%0d ret=%0d want 0/0", ifBig.State, ifBig.Retired);
      end
   endtask

   task automatic test_lw();
      runInstr(OP_LW, 100, -1);
      runInstr(OP_LW, 100, 2);
   endtask

   task automatic test_sw_stall();
      runInstr(OP_SW, 100, 3);
   endtask

   task automatic test_branch_jump();
      runInstr(OP_BNE, 100, -1);
      runInstr(OP_BEQ, 100, -1);
      runInstr(OP_J,   100, -1);
      runInstr(OP_ADDI, 100, -1);
   endtask

   task automatic test_illegal();
      runInstr(6'b111111, 100, -1);
      runInstr(OP_ANDI, 100, -1);
      runInstr(OP_ORI,  100, -1);
   endtask

   task automatic test_reset_mid_access();
      instruction = OP_LW;
      memReady = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      memReady = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      nTests++;
      if (ifBig.State !== 4'd3 || actCtrl() !== '0) begin
         nFail++;
         $display("FAIL reset_mid got st=%0d ctrl=%b want 3/0", ifBig.State, actCtrl());
      end
      @(posedge clk); #1;
      rst = 1'b0;
      retModel = '0;
      nTests++;
      if (ifBig.State !== 4'd0 || ifBig.Retired !== 16'd0) begin
         nFail++;
         $display("FAIL reset_mid_after got st=%0d ret=%0d want 0/0", ifBig.State, ifBig.Retired);
      end
   endtask

   task automatic test_wrap();
      test_reset();
      repeat (4) runInstr(OP_R, 100, -1);
      @(negedge clk);
      nTests++;
      if (ifSmall.Retired !== 2'd0 || ifBig.Retired !== 16'd4) begin
         nFail++;
         $display("FAIL wrap got %0d/%0d want 0/4", ifSmall.Retired, ifBig.Retired);
      end
      @(posedge clk); #1;
      memReady = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [5:0] ops[10];
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI, OP_ANDI, OP_ORI, 6'h00};
      for (int n = 0; n < 200; n++) begin
         int k;
         logic [5:0] op;
         k = $urandom_range(0, 10);
         op = (k == 10) ? 6'($urandom_range(0, 63)) : ops[k];
         runInstr(op, $urandom_range(30, 100), -1);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_stall();
      test_branch_jump();
      test_illegal();
      test_reset_mid_access();
      test_wrap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter (2..32).
REQ-002 Parameter ALUOP_W, default 2, width of ALUOp (>=2); upper bits beyond [1:0] SHALL be driven 0.
REQ-003 clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 instruction  input  6  opcode field from the instruction register; stable from DECODE until the instruction completes.
REQ-006 mem_ready  input  1  memory handshake; high = current memory access completes this cycle.
REQ-007 PCWrite, PCWriteCondE, PCWriteCondNE, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls.
REQ-008 PCSource  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
REQ-009 ALUSrcB  output  2  00 register B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
REQ-010 ALUOp  output  ALUOP_W  00 add, 01 subtract, 10 funct-decoded, 11 logical immediate.
REQ-011 Illegal  output  1  one-cycle pulse on unrecognised opcode.
REQ-012 Retired  output  CNT_W  count of completed instructions.
REQ-013 State  output  4  current state encoding, debug only.

Function
REQ-014 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, IMMEX 10, IMMWB 11; encodings 12-15 SHALL go to FETCH on the next edge.
REQ-015 Outputs SHALL be combinational from State, instruction and mem_ready only; any output not listed for a state SHALL be 0.
REQ-016 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite and PCWrite SHALL equal mem_ready; stay until mem_ready=1, then DECODE.
REQ-017 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next state by opcode: 000000 EXEC, 100011/101011 MEMADR, 000100/000101 BRANCH, 000010 JUMP, 001000 IMMEX; any other opcode SHALL pulse Illegal for this cycle and go to FETCH.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEMRD for 100011, MEMWR for 101011.
REQ-019 MEMRD: MemRead=1, IorD=1; hold until mem_ready=1, then MEMWB.
REQ-020 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next FETCH.
REQ-021 MEMWR: MemWrite=1, IorD=1; hold until mem_ready=1, then FETCH.
REQ-022 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next RWB. RWB: RegDst=1, RegWrite=1; next FETCH.
REQ-023 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01; PCWriteCondE=1 for 000100, PCWriteCondNE=1 for 000101; next FETCH.
REQ-024 JUMP: PCWrite=1, PCSource=10; next FETCH.
REQ-025 IMMEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 for addi; next IMMWB. IMMWB: RegDst=0, RegWrite=1; next FETCH.
REQ-026 Retired SHALL increment by 1 on every edge leaving MEMWB, MEMWR (with mem_ready), RWB, BRANCH, JUMP or IMMWB; it SHALL wrap modulo 2^CNT_W; an illegal opcode SHALL NOT count.
REQ-027 Latencies with mem_ready held high: lw 5 cycles, sw 4, R-type 4, addi 4, beq/bne 3, j 3.

Reset
REQ-028 While rst=1 at a rising edge, State SHALL become FETCH and Retired 0, regardless of current state, including mid memory access.
REQ-029 While rst=1, every control output and Illegal SHALL be forced 0 combinationally.

Configuration
REQ-030 Macro MULTICYCLE_CONTROL_IMM_LOGIC_EN defined: opcodes 001100 (andi) and 001101 (ori) SHALL decode to IMMEX with ALUOp=11, then IMMWB, and count as retired.
REQ-031 Macro undefined: 001100 and 001101 SHALL be illegal per REQ-017.

Verification
REQ-032 lw (100011), mem_ready=1 -> State 0,1,2,3,4,0; MemtoReg=RegWrite=1 in state 4; Retired 0->1.
REQ-033 sw (101011), mem_ready low 3 cycles in MEMWR -> MemWrite=1 for 4 cycles; Retired increments only on exit.
REQ-034 bne (000101) -> PCWriteCondNE=1, ALUOp=01 in cycle 3, PCWriteCondE=0; back to FETCH.
REQ-035 opcode 111111 -> Illegal=1 for one DECODE cycle, next FETCH, Retired unchanged.
REQ-036 rst asserted in MEMRD with mem_ready=0 -> outputs 0 that cycle, State=0, Retired=0 after edge.
REQ-037 CNT_W=2, four R-type instructions -> Retired 1,2,3,0; ori with macro ALUOp=11, without Illegal=1.
